// File: rtl/csr_console_pkg.sv
// Shared definitions for the console-output CSR: address, write-word fields,
// status-word fields and the sequencer state encoding.
package csr_console_pkg;

    localparam logic [11:0] CSR_CONSOLE_ADR = 12'h0FF;

    localparam int WB_START    = 11;
    localparam int WB_CHAR_MSB = 10;
    localparam int WB_CHAR_LSB = 3;
    localparam int WB_STOP     = 2;
    localparam int WB_EXIT     = 1;
    localparam int WB_FAIL     = 0;

    localparam int SB_ONE       = 2;
    localparam int SB_FULL      = 12;
    localparam int SB_EMPTY     = 13;
    localparam int SB_OVF       = 14;
    localparam int SB_EXIT      = 15;
    localparam int SB_COUNT_LSB = 16;
    localparam int SB_COUNT_MSB = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } con_state_e;

    function automatic logic [63:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic       exit_pend,
                                                input logic [7:0] count);
        logic [63:0] word_v;
        word_v                             = 64'd0;
        word_v[SB_ONE]                     = 1'b1;
        word_v[SB_FULL]                    = full;
        word_v[SB_EMPTY]                   = empty;
        word_v[SB_OVF]                     = ovf;
        word_v[SB_EXIT]                    = exit_pend;
        word_v[SB_COUNT_MSB:SB_COUNT_LSB]  = count;
        return word_v;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// DEPTH x 8 character FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module console_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_r == CW'(DEPTH));
    assign empty_o   = (count_r == CW'(0));
    assign count_o   = count_r;
    assign head_o    = mem_r[rd_ptr_r];
    assign push_ok_s = push_i & (~full_o | pop_i);
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

    // Character storage; contents need no reset since the pointers gate them.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/csr_console_tx.sv
// Console-output CSR at 0x0FF: queues characters and exit requests, then
// paces them out to a valid/ready character sink and pulses halt when drained.
module csr_console_tx
    import csr_console_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int GAP   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] cadr_i,
    output logic        cvalid_o,
    output logic [63:0] cdat_o,
    input  logic [63:0] cdat_i,
    input  logic        coe_i,
    input  logic        cwe_i,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic        halt_o,
    output logic        fail_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    con_state_e    state_r, state_nxt_s;
    logic [GW-1:0] gap_r, gap_nxt_s;
    logic          ovf_r, exit_pend_r, fail_pend_r;
    logic [7:0]    char_r;
    logic          char_valid_r, halt_r, fail_r;

    logic          wr_s, rd_clr_s, push_s, pop_s, drop_s, exit_wr_s;
    logic          full_s, empty_s;
    logic [7:0]    head_s;
    logic [CW-1:0] count_s;
    logic [15:0]   count_ext_s;
    logic          ctl_unused_s;

    assign cvalid_o     = (cadr_i == CSR_CONSOLE_ADR);
    assign wr_s         = cvalid_o & cwe_i;
    assign rd_clr_s     = cvalid_o & coe_i & ~cwe_i;
    assign push_s       = wr_s & cdat_i[WB_START] & ~cdat_i[WB_STOP];
    assign exit_wr_s    = wr_s & cdat_i[WB_EXIT];
    assign drop_s       = push_s & full_s & ~pop_s;
    assign count_ext_s  = 16'(count_s);
    assign ctl_unused_s = ^{cdat_i[63:12], count_ext_s[15:8]};

    assign char_o       = char_r;
    assign char_valid_o = char_valid_r;
    assign halt_o       = halt_r;
    assign fail_o       = fail_r;

    console_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .data_i  (cdat_i[WB_CHAR_MSB:WB_CHAR_LSB]),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Status read-back, visible in the same cycle as the address.
    always_comb begin
        cdat_o = 64'd0;
        if (cvalid_o) begin
            cdat_o = status_word(full_s, empty_s, ovf_r, exit_pend_r, count_ext_s[7:0]);
        end else begin
            cdat_o = 64'd0;
        end
    end

    // Sequencer next-state; DONE waits out a same-cycle push so halt follows every char.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = ST_SEND;
                end else if (exit_pend_r && !push_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (char_ready_i) begin
                    pop_s     = 1'b1;
                    gap_nxt_s = GAP_LOAD;
                    if (GAP > 0) begin
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_GAP: begin
                gap_nxt_s = gap_r - GAP_ONE;
                if (gap_r <= GAP_ONE) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered sink/halt outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            gap_r        <= '0;
            char_r       <= 8'd0;
            char_valid_r <= 1'b0;
            halt_r       <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            gap_r        <= gap_nxt_s;
            char_valid_r <= (state_nxt_s == ST_SEND);
            halt_r       <= (state_nxt_s == ST_DONE);
            fail_r       <= (state_nxt_s == ST_DONE) &
                            (fail_pend_r | (exit_wr_s & cdat_i[WB_FAIL]));
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_SEND)) begin
                char_r <= head_s;
            end
        end
    end

    // Sticky overflow and pending exit/fail flags.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf_r       <= 1'b0;
            exit_pend_r <= 1'b0;
            fail_pend_r <= 1'b0;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (rd_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (exit_wr_s) begin
                exit_pend_r <= 1'b1;
                fail_pend_r <= ((state_r == ST_DONE) ? 1'b0 : fail_pend_r) | cdat_i[WB_FAIL];
            end else if (state_r == ST_DONE) begin
                exit_pend_r <= 1'b0;
                fail_pend_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_console_tx.sv
// Randomised and directed bench for csr_console_tx against a queue-based
// model of the FIFO, sticky flags and exit handshake.
module tb_csr_console_tx;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cadr = 12'd0;
    logic [63:0] wdat = 64'd0;
    logic        coe = 1'b0, cwe = 1'b0, ready = 1'b0;
    logic        cvalid_o, char_valid_o, halt_o, fail_o;
    logic [63:0] cdat_o;
    logic [7:0]  char_o;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] q[$];
    logic m_ovf, m_exit, m_fail;
    int accepted = 0, halt_cnt = 0;
    logic s_valid, s_halt, s_fail;
    logic [7:0] s_char;
    logic [63:0] s_cdat;
    int s_cyc;
    logic prev_stall = 1'b0;
    logic [7:0] prev_char = 8'd0;

    csr_console_tx #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_i(clk), .reset_i(rst), .cadr_i(cadr), .cvalid_o(cvalid_o),
        .cdat_o(cdat_o), .cdat_i(wdat), .coe_i(coe), .cwe_i(cwe),
        .char_o(char_o), .char_valid_o(char_valid_o), .char_ready_i(ready),
        .halt_o(halt_o), .fail_o(fail_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [63:0] char_word(input logic [7:0] c);
        return {52'd0, 1'b1, c, 3'b000};
    endfunction

    function automatic logic [63:0] model_status();
        logic [63:0] s;
        s        = 64'h4;
        s[12]    = (q.size() == DEPTH);
        s[13]    = (q.size() == 0);
        s[14]    = m_ovf;
        s[15]    = m_exit;
        s[23:16] = 8'(q.size());
        return s;
    endfunction

    task automatic set_idle();
        cadr = 12'd0; wdat = 64'd0; coe = 1'b0; cwe = 1'b0;
    endtask

    task automatic set_write(input logic [63:0] w);
        cadr = 12'h0FF; wdat = w; coe = 1'b0; cwe = 1'b1;
    endtask

    task automatic set_read(input logic oe);
        cadr = 12'h0FF; wdat = 64'd0; coe = oe; cwe = 1'b0;
    endtask

    // One clock: sample mid-cycle, check sink/CSR behaviour, advance model at the edge.
    task automatic tick();
        logic sel, wr, push, exitw, rd, hs, full, rs, hl;
        logic [7:0] c;
        #4;
        s_valid = char_valid_o; s_char = char_o; s_halt = halt_o;
        s_fail = fail_o; s_cdat = cdat_o; s_cyc = cyc;
        sel = (cadr == 12'h0FF); wr = sel & cwe; rd = sel & ~cwe;
        push = wr & wdat[11] & ~wdat[2]; exitw = wr & wdat[1];
        c = wdat[10:3]; hs = char_valid_o & ready; rs = rst; hl = halt_o;
        if (!rs) begin
            checks++;
            if (cvalid_o !== sel) begin
                errors++; $display("FAIL cvalid: got %0b expected %0b", cvalid_o, sel);
            end
            if (rd) begin
                checks++;
                if (cdat_o !== model_status()) begin
                    errors++; $display("FAIL status: got %h expected %h", cdat_o, model_status());
                end
            end else if (!sel) begin
                checks++;
                if (cdat_o !== 64'd0) begin
                    errors++; $display("FAIL cdat_unsel: got %h expected 0", cdat_o);
                end
            end
            if (char_valid_o) begin
                checks++;
                if (q.size() == 0 || char_o !== q[0]) begin
                    errors++;
                    $display("FAIL char_head: got %02h expected %02h (queued %0d)",
                             char_o, (q.size() > 0) ? q[0] : 8'h00, q.size());
                end
            end
            if (prev_stall) begin
                checks++;
                if (char_valid_o !== 1'b1 || char_o !== prev_char) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b c=%02h expected v=1 c=%02h",
                             char_valid_o, char_o, prev_char);
                end
            end
            checks++;
            if (halt_o) begin
                if (char_valid_o || q.size() != 0 || !m_exit || fail_o !== m_fail) begin
                    errors++;
                    $display("FAIL halt: got v=%0b fail=%0b queued=%0d exit=%0b expected v=0 fail=%0b queued=0 exit=1",
                             char_valid_o, fail_o, q.size(), m_exit, m_fail);
                end
            end else if (fail_o !== 1'b0) begin
                errors++; $display("FAIL fail_alone: got %0b expected 0", fail_o);
            end
        end
        @(posedge clk);
        if (rs) begin
            q.delete(); m_ovf = 1'b0; m_exit = 1'b0; m_fail = 1'b0; prev_stall = 1'b0;
        end else begin
            full = (q.size() == DEPTH);
            if (hs && q.size() > 0) begin
                void'(q.pop_front()); accepted++;
            end
            if (push) begin
                if (!full || hs) q.push_back(c);
                else m_ovf = 1'b1;
            end
            if (rd && coe) m_ovf = 1'b0;
            if (hl) begin
                m_exit = 1'b0; m_fail = 1'b0; halt_cnt++;
            end
            if (exitw) begin
                m_exit = 1'b1; m_fail = m_fail | wdat[0];
            end
            prev_stall = char_valid_o & ~ready;
            prev_char  = char_o;
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; set_idle(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set_read(1'b0); #1;
        checks++;
        if (cvalid_o !== 1'b1 || cdat_o !== 64'h0000_0000_0000_2004) begin
            errors++; $display("FAIL reset_status: got v=%0b %h expected v=1 2004", cvalid_o, cdat_o);
        end
        checks++;
        if (char_valid_o !== 1'b0 || char_o !== 8'd0 || halt_o !== 1'b0 || fail_o !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got v=%0b c=%02h h=%0b f=%0b expected 0",
                               char_valid_o, char_o, halt_o, fail_o);
        end
        cadr = 12'h0FE; #1;
        checks++;
        if (cvalid_o !== 1'b0 || cdat_o !== 64'd0) begin
            errors++; $display("FAIL other_addr: got v=%0b %h expected v=0 0", cvalid_o, cdat_o);
        end
        set_idle(); tick();
    endtask

    task automatic test_single();
        int k;
        int vq[$];
        logic [7:0] cq[$];
        ready = 1'b1;
        set_write(char_word(8'h41)); tick(); k = s_cyc;
        if (s_valid) vq.push_back(s_cyc);
        set_write(char_word(8'h42)); tick();
        if (s_valid) vq.push_back(s_cyc);
        set_idle();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_valid) begin vq.push_back(s_cyc); cq.push_back(s_char); end
        end
        checks++;
        if (vq.size() != 2) begin
            errors++; $display("FAIL valid_cycles: got %0d expected 2", vq.size());
        end else begin
            checks++;
            if (vq[0] != k + 2) begin
                errors++; $display("FAIL latency: got %0d expected %0d", vq[0] - k, 2);
            end
            checks++;
            if (vq[1] - vq[0] != GAP + 2) begin
                errors++; $display("FAIL pacing: got %0d expected %0d", vq[1] - vq[0], GAP + 2);
            end
            checks++;
            if (cq[0] !== 8'h41 || cq[1] !== 8'h42) begin
                errors++; $display("FAIL order_ab: got %02h %02h expected 41 42", cq[0], cq[1]);
            end
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_write(char_word(8'(8'h30 + i))); tick();
        end
        set_idle(); tick(); tick();
        set_read(1'b0); tick();
        checks++;
        if (s_cdat !== 64'h0000_0000_0008_5004) begin
            errors++; $display("FAIL ovf_set: got %h expected 85004", s_cdat);
        end
        tick();
        checks++;
        if (s_cdat !== 64'h0000_0000_0008_5004) begin
            errors++; $display("FAIL ovf_noclear: got %h expected 85004", s_cdat);
        end
        set_read(1'b1); tick();
        set_read(1'b0); tick();
        checks++;
        if (s_cdat !== 64'h0000_0000_0008_1004) begin
            errors++; $display("FAIL ovf_clear: got %h expected 81004", s_cdat);
        end
    endtask

    task automatic test_full_pop();
        ready = 1'b1;
        set_write(char_word(8'h5A)); tick();
        ready = 1'b0;
        set_read(1'b0); tick();
        checks++;
        if (s_cdat !== 64'h0000_0000_0008_1004) begin
            errors++; $display("FAIL full_pop: got %h expected 81004", s_cdat);
        end
        set_idle(); ready = 1'b1;
        for (int i = 0; i < 200 && (q.size() != 0 || s_valid); i++) tick();
        set_read(1'b0); tick(); set_idle();
        checks++;
        if (s_cdat !== 64'h0000_0000_0000_2004) begin
            errors++; $display("FAIL drained: got %h expected 2004", s_cdat);
        end
    endtask

    task automatic test_exit();
        int acc0, h0;
        logic got_fail;
        logic [7:0] cq[$];
        ready = 1'b1; acc0 = accepted; h0 = halt_cnt; got_fail = 1'b0;
        set_write(char_word(8'h48)); tick();
        set_write(char_word(8'h49)); tick();
        set_write(64'h3); tick();
        set_idle();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (s_valid) cq.push_back(s_char);
            if (s_halt) got_fail = s_fail;
        end
        checks++;
        if (halt_cnt - h0 != 1 || got_fail !== 1'b1) begin
            errors++; $display("FAIL exit_halt: got halts=%0d fail=%0b expected 1 1", halt_cnt - h0, got_fail);
        end
        checks++;
        if (accepted - acc0 != 2 || cq.size() != 2 || cq[0] !== 8'h48 || cq[1] !== 8'h49) begin
            errors++; $display("FAIL exit_chars: got %0d accepted expected 2 (48,49)", accepted - acc0);
        end
        set_read(1'b0); tick(); set_idle();
        checks++;
        if (s_cdat !== 64'h0000_0000_0000_2004) begin
            errors++; $display("FAIL exit_cleared: got %h expected 2004", s_cdat);
        end
    endtask

    task automatic test_reset_mid();
        int h0, vcnt;
        ready = 1'b0;
        set_write(char_word(8'h61)); tick();
        set_write(char_word(8'h62) | 64'h2); tick();
        set_idle();
        for (int i = 0; i < 10 && !s_valid; i++) tick();
        checks++;
        if (!s_valid) begin
            errors++; $display("FAIL pre_reset_valid: got 0 expected 1");
        end
        rst = 1'b1; tick(); rst = 1'b0;
        set_read(1'b0); tick(); set_idle();
        checks++;
        if (s_valid !== 1'b0 || s_cdat !== 64'h0000_0000_0000_2004) begin
            errors++; $display("FAIL reset_mid: got v=%0b %h expected v=0 2004", s_valid, s_cdat);
        end
        ready = 1'b1; h0 = halt_cnt; vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_valid) vcnt++;
        end
        checks++;
        if (halt_cnt != h0 || vcnt != 0) begin
            errors++; $display("FAIL reset_quiet: got halts=%0d chars=%0d expected 0 0", halt_cnt - h0, vcnt);
        end
    endtask

    task automatic test_random();
        int r;
        logic [63:0] w;
        for (int i = 0; i < 800; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                w = char_word(8'($urandom_range(0, 255)));
                if (r == 3) w[2] = 1'b1;
                if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(2, 3));
                set_write(w);
            end else if (r < 6) begin
                set_read(1'($urandom_range(0, 1)));
            end else if (r == 6) begin
                cadr = 12'($urandom_range(0, 4094));
                if (cadr == 12'h0FF) cadr = 12'h000;
                wdat = {$urandom, $urandom}; cwe = 1'($urandom_range(0, 1)); coe = 1'b1;
            end else if (r == 7) begin
                set_write({62'd0, 1'b1, 1'($urandom_range(0, 1))});
            end else begin
                set_idle();
            end
            tick();
        end
        set_idle(); ready = 1'b1;
        for (int i = 0; i < 400 && (q.size() != 0 || m_exit); i++) tick();
        checks++;
        if (q.size() != 0 || m_exit) begin
            errors++; $display("FAIL random_drain: got queued=%0d exit=%0b expected 0 0", q.size(), m_exit);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_exit();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
